// File: rtl/contador_de_programa_pkg.sv
// Shared ISA and control definitions for the fetch-side program counter.
// The opcode values and state encodings are reused by the decoder and control unit.
package contador_de_programa_pkg;

    localparam int PC_W    = 26;
    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;

    localparam logic [OPC_W-1:0] OP_JUMP = 6'b010110;
    localparam logic [OPC_W-1:0] OP_IN   = 6'b010011;
    localparam logic [OPC_W-1:0] OP_HALT = 6'b011000;

    // Encoding 2'd3 is illegal and is trapped as a range-style error.
    typedef enum logic [1:0] {
        BUSCA          = 2'd0,
        ESPERA_ENTRADA = 2'd1,
        PARADO         = 2'd2
    } estado_t;

    function automatic logic [OPC_W-1:0] opcode_de(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:INSTR_W-OPC_W];
    endfunction

endpackage

// File: rtl/contador_de_programa_borda.sv
// Rising-edge detector for the user confirm button. The history starts at 1 so that
// a button already held down when reset is released does not count as a press.
module detector_de_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic borda
);

    logic historico;

    // Track the previous sample of the button level.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) historico <= 1'b1;
        else        historico <= entrada;
    end

    assign borda = entrada & ~historico;

endmodule

// File: rtl/contador_de_programa.sv
// Fetch-side program counter: holds the PC, selects the next PC, pre-decodes IN and
// HALT to stall or freeze the core, and qualifies commits through 'executa'.
module contador_de_programa
    import contador_de_programa_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 26'd0,
    parameter logic [PC_W-1:0] LIMITE_PC    = 26'd150
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instrucao,
    input  logic               desvio,
    input  logic [PC_W-1:0]    endereco_desvio,
    input  logic               salto_reg,
    input  logic [PC_W-1:0]    endereco_reg,
    input  logic               confirma,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_mais_um,
    output logic               executa,
    output logic [1:0]         estado,
    output logic               parado,
    output logic               erro
);

    estado_t           estado_q, estado_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              erro_q, erro_d;
    logic              borda;
    logic [OPC_W-1:0]  opcode;
    logic              fora_de_faixa;

    detector_de_borda u_borda (
        .clock   (clock),
        .reset   (reset),
        .entrada (confirma),
        .borda   (borda)
    );

    assign opcode        = opcode_de(instrucao);
    assign fora_de_faixa = (pc_q >= LIMITE_PC);
    assign pc_mais_um    = pc_q + PC_W'(1);

    // State register: PC, FSM state and error flag; reset returns to the reset vector.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            estado_q <= BUSCA;
            erro_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            estado_q <= estado_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state and next-PC selection; fetch decisions follow the priority order below.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        pc_d     = pc_q;
        estado_d = estado_q;
        erro_d   = erro_q;
        case (estado_q)
            BUSCA: begin
                if (fora_de_faixa) begin
                    estado_d = PARADO;
                    erro_d   = 1'b1;
                end else if (opcode == OP_HALT) begin
                    estado_d = PARADO;
                end else if (opcode == OP_IN) begin
                    estado_d = ESPERA_ENTRADA;
                end else if (opcode == OP_JUMP) begin
                    pc_d = instrucao[PC_W-1:0];
                end else if (salto_reg) begin
                    pc_d = endereco_reg;
                end else if (desvio) begin
                    pc_d = endereco_desvio;
                end else begin
                    pc_d = pc_mais_um;
                end
            end
            ESPERA_ENTRADA: begin
                if (borda) begin
                    pc_d     = pc_mais_um;
                    estado_d = BUSCA;
                end
            end
            PARADO: begin
                // Frozen until reset.
            end
            default: begin
                estado_d = PARADO;
                erro_d   = 1'b1;
            end
        endcase
    end

    // Commit qualifier: only a normally retiring instruction or a completed IN writes.
    always_comb begin
        executa = 1'b0;
        if (reset) begin
            case (estado_q)
                BUSCA:          executa = !(fora_de_faixa || opcode == OP_HALT || opcode == OP_IN);
                ESPERA_ENTRADA: executa = borda;
                default:        executa = 1'b0;
            endcase
        end
    end

    assign pc     = pc_q;
    assign estado = estado_q;
    assign parado = (estado_q == PARADO);
    assign erro   = erro_q;

endmodule

// File: tb/tb_contador_de_programa.sv
// Directed bench for contador_de_programa: a vector table for single-cycle PC selection
// and hand-written sequences for IN waiting, HALT, range error and reset corners.
module tb_contador_de_programa;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instrucao;
    logic        desvio;
    logic [25:0] endereco_desvio;
    logic        salto_reg;
    logic [25:0] endereco_reg;
    logic        confirma;
    logic [25:0] pc;
    logic [25:0] pc_mais_um;
    logic        executa;
    logic [1:0]  estado;
    logic        parado;
    logic        erro;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] NOP     = 32'h0400_0000;   // opcode 000001
    localparam logic [31:0] W_IN    = {6'b010011, 26'd0};
    localparam logic [31:0] W_HALT  = {6'b011000, 26'd0};

    contador_de_programa dut (
        .clock           (clock),
        .reset           (reset),
        .instrucao       (instrucao),
        .desvio          (desvio),
        .endereco_desvio (endereco_desvio),
        .salto_reg       (salto_reg),
        .endereco_reg    (endereco_reg),
        .confirma        (confirma),
        .pc              (pc),
        .pc_mais_um      (pc_mais_um),
        .executa         (executa),
        .estado          (estado),
        .parado          (parado),
        .erro            (erro)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic        d;
        logic [25:0] ed;
        logic        sr;
        logic [25:0] er;
        logic        conf;
        logic        exp_exec;
        logic [25:0] exp_pc;
    } vetor_t;

    function automatic logic [31:0] jump(input logic [25:0] alvo);
        return {6'b010110, alvo};
    endfunction

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual === esperado) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic d, input logic [25:0] ed,
                         input logic sr, input logic [25:0] er, input logic conf);
        instrucao       = instr;
        desvio          = d;
        endereco_desvio = ed;
        salto_reg       = sr;
        endereco_reg    = er;
        confirma        = conf;
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check("executa_in_reset", executa, 0);
        tick();
        reset = 1'b1;
        check("reset_pc", pc, 0);
        check("reset_estado", estado, 0);
        check("reset_parado", parado, 0);
        check("reset_erro", erro, 0);
    endtask

    vetor_t tabela[9];

    initial begin
        tabela[0] = '{NOP,       0, 26'd0,  0, 26'd0,  0, 1, 26'd1};
        tabela[1] = '{NOP,       0, 26'd0,  0, 26'd0,  0, 1, 26'd2};
        tabela[2] = '{NOP,       0, 26'd0,  0, 26'd0,  0, 1, 26'd3};
        tabela[3] = '{NOP,       0, 26'd0,  0, 26'd0,  0, 1, 26'd4};
        tabela[4] = '{jump(1),   0, 26'd0,  0, 26'd0,  0, 1, 26'd1};
        tabela[5] = '{NOP,       1, 26'd7,  1, 26'd9,  0, 1, 26'd9};
        tabela[6] = '{NOP,       1, 26'd7,  0, 26'd0,  0, 1, 26'd7};
        tabela[7] = '{NOP,       0, 26'd0,  1, 26'd2,  1, 1, 26'd2};
        tabela[8] = '{jump(2),   1, 26'd40, 1, 26'd50, 1, 1, 26'd2};

        drive(NOP, 0, 0, 0, 0, 0);
        check("executa_in_reset", executa, 0);
        tick();
        tick();
        check("reset_pc", pc, 0);
        check("reset_estado", estado, 0);
        check("reset_parado", parado, 0);
        check("reset_erro", erro, 0);
        reset = 1'b1;

        // Single-cycle PC selection.
        for (int i = 0; i < 9; i++) begin
            drive(tabela[i].instr, tabela[i].d, tabela[i].ed, tabela[i].sr, tabela[i].er, tabela[i].conf);
            check($sformatf("vec%0d_executa", i), executa, tabela[i].exp_exec);
            tick();
            check($sformatf("vec%0d_pc", i), pc, tabela[i].exp_pc);
        end

        // IN at pc=2 with the button already held: must wait for a fresh press.
        drive(W_IN, 0, 0, 0, 0, 1);
        check("in_fetch_executa", executa, 0);
        tick();
        check("in_wait_estado", estado, 1);
        check("in_wait_pc", pc, 2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("in_held_executa", executa, 0);
            tick();
            check("in_held_pc", pc, 2);
            check("in_held_estado", estado, 1);
        end
        drive(W_IN, 0, 0, 0, 0, 0);
        check("in_release_executa", executa, 0);
        tick();
        drive(W_IN, 0, 0, 0, 0, 1);
        check("in_press_executa", executa, 1);
        tick();
        check("in_done_pc", pc, 3);
        check("in_done_estado", estado, 0);

        // Another IN at pc=3 while the button stays held for 10 cycles: no second advance.
        #1;
        check("in2_fetch_executa", executa, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            check("in2_held_executa", executa, 0);
            tick();
            check("in2_held_pc", pc, 3);
        end
        drive(W_IN, 0, 0, 0, 0, 0);
        tick();
        drive(W_IN, 0, 0, 0, 0, 1);
        check("in2_press_executa", executa, 1);
        tick();
        check("in2_done_pc", pc, 4);

        // HALT at pc=20 freezes the core regardless of other requests.
        drive(jump(20), 0, 0, 0, 0, 0);
        tick();
        check("halt_jump_pc", pc, 20);
        drive(W_HALT, 1, 26'd7, 1, 26'd9, 0);
        check("halt_fetch_executa", executa, 0);
        tick();
        check("halt_estado", estado, 2);
        check("halt_parado", parado, 1);
        check("halt_erro", erro, 0);
        for (int i = 0; i < 50; i++) begin
            confirma = ~confirma;
            #1;
            check("halt_executa", executa, 0);
            tick();
            check("halt_pc", pc, 20);
            check("halt_parado", parado, 1);
        end
        drive(W_HALT, 0, 0, 0, 0, 0);
        pulse_reset();

        // Sequential run up to the memory limit, then range error.
        drive(NOP, 0, 0, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            check("seq_executa", executa, 1);
            tick();
            check("seq_pc", pc, 26'(i + 1));
        end
        check("range_executa", executa, 0);
        tick();
        check("range_estado", estado, 2);
        check("range_erro", erro, 1);
        check("range_parado", parado, 1);
        check("range_pc", pc, 150);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("range_hold_pc", pc, 150);
            check("range_hold_erro", erro, 1);
        end
        pulse_reset();

        // Branch target taken verbatim; pc_mais_um wraps; range check fires on fetch.
        drive(NOP, 1, 26'h3FF_FFFF, 0, 0, 0);
        tick();
        check("far_pc", pc, 26'h3FF_FFFF);
        check("wrap_pc_mais_um", pc_mais_um, 0);
        drive(NOP, 0, 0, 0, 0, 0);
        check("far_executa", executa, 0);
        tick();
        check("far_erro", erro, 1);
        check("far_pc_held", pc, 26'h3FF_FFFF);
        pulse_reset();

        // Reset during IN wait with the button held: no spurious commit afterwards.
        drive(W_IN, 0, 0, 0, 0, 0);
        tick();
        check("rin_wait_estado", estado, 1);
        confirma = 1'b1;
        pulse_reset();
        tick();
        check("rin_refetch_estado", estado, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rin_held_executa", executa, 0);
            tick();
        end
        drive(W_IN, 0, 0, 0, 0, 0);
        check("rin_release_executa", executa, 0);
        tick();
        check("rin_release_pc", pc, 0);
        check("rin_release_estado", estado, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
